// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] FETCH_STEP       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and a registered head word.
// The head register shows EMPTY_HEAD whenever the FIFO holds nothing.
module sync_fifo #(
  parameter int               WIDTH      = 64,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] EMPTY_HEAD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  // The head is looked up from the next-state array so a push into an empty FIFO is visible next cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = EMPTY_HEAD;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
    if (count_d != '0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= EMPTY_HEAD;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads, buffers in-order responses,
// and restarts on redirect while discarding responses to stale requests.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        MEM_REQ_VALID,
  input  logic        MEM_REQ_READY,
  output logic [31:0] MEM_REQ_ADDR,
  input  logic        MEM_RSP_VALID,
  input  logic [31:0] MEM_RSP_DATA,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DROP_W = CNT_W + 2;

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0]  buf_count;
  logic              buf_full, buf_empty;
  logic [CNT_W:0]    in_use;
  logic              req_fire, rsp_keep, rsp_drop, buf_push, buf_pop;
  fetch_entry_t      push_entry, head_entry;

  // Outstanding counts only live requests; stale ones move into drop and stop limiting issue.
  always_comb begin
    in_use        = {1'b0, buf_count} + {1'b0, outstanding_q};
    MEM_REQ_VALID = !RST && !buf_full && (in_use < (CNT_W+1)'(DEPTH));
    MEM_REQ_ADDR  = fetch_pc_q;
    req_fire      = MEM_REQ_VALID && MEM_REQ_READY;
    rsp_drop      = MEM_RSP_VALID && (drop_q != '0);
    rsp_keep      = MEM_RSP_VALID && (drop_q == '0);
    buf_push      = rsp_keep && !REDIRECT;
    buf_pop       = INSTR_READY && !buf_empty;

    push_entry.pc    = rsp_pc_q;
    push_entry.instr = MEM_RSP_DATA;

    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;

    if (REDIRECT) begin
      fetch_pc_d    = word_align(REDIRECT_PC);
      rsp_pc_d      = word_align(REDIRECT_PC);
      outstanding_d = '0;
      drop_d        = drop_q + DROP_W'(outstanding_q) + DROP_W'(req_fire)
                      - DROP_W'(MEM_RSP_VALID);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + FETCH_STEP;
      end
      if (buf_push) begin
        rsp_pc_d = rsp_pc_q + FETCH_STEP;
      end
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      if (rsp_drop) begin
        drop_d = drop_q - DROP_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH     ($bits(fetch_entry_t)),
    .DEPTH     (DEPTH),
    .EMPTY_HEAD({RESET_PC, 32'h0000_0000})
  ) u_buf (
    .clk      (CLK),
    .rst      (RST),
    .push     (buf_push),
    .push_data(push_entry),
    .pop      (buf_pop),
    .flush    (REDIRECT),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count),
    .head     (head_entry)
  );

  assign INSTR_VALID = !buf_empty;
  assign INSTR       = head_entry.instr;
  assign INSTR_PC    = head_entry.pc;

endmodule
